// File: rtl/branch_resolve.sv
// branch_resolve: carries fetch predictions through D and X, resolves them against the actual
// outcome, redirects on mispredict and trains the predictor through a registered write port.
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 12,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             f_valid_i,
    input  logic [XLEN-1:0]  f_pc_i,
    input  logic             f_pred_taken_i,
    input  logic [XLEN-1:0]  f_pred_target_i,
    input  logic             x_is_ctrl_i,
    input  logic             x_taken_i,
    input  logic [XLEN-1:0]  x_target_i,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic             upd_en_o,
    output logic [IDX_W-1:0] upd_idx_o,
    output logic [XLEN-1:0]  upd_target_o,
    output logic             upd_valid_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o
);
    logic             fd_valid_q, fd_valid_d, fd_pt_q, fd_pt_d;
    logic [XLEN-1:0]  fd_pc_q, fd_pc_d, fd_tgt_q, fd_tgt_d;
    logic             dx_valid_q, dx_valid_d, dx_pt_q, dx_pt_d;
    logic [XLEN-1:0]  dx_pc_q, dx_pc_d, dx_tgt_q, dx_tgt_d;
    logic             upd_en_q, upd_en_d, upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic [XLEN-1:0]  upd_target_q, upd_target_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
    logic             resolve, mispredict;
    logic [XLEN-1:0]  act_next;

    always_comb begin
        resolve      = dx_valid_q & ~stall_i;
        act_next     = x_taken_i ? x_target_i : dx_pc_q + XLEN'(4);
        // aliasing (predicted taken, not control) falls out as pred_taken != x_taken
        mispredict   = resolve & ((dx_pt_q != x_taken_i) |
                                  (dx_pt_q & x_taken_i & (dx_tgt_q != x_target_i)));
        fd_valid_d   = stall_i ? fd_valid_q : f_valid_i & ~mispredict;
        fd_pc_d      = stall_i ? fd_pc_q    : f_pc_i;
        fd_pt_d      = stall_i ? fd_pt_q    : f_pred_taken_i;
        fd_tgt_d     = stall_i ? fd_tgt_q   : f_pred_target_i;
        dx_valid_d   = stall_i ? dx_valid_q : fd_valid_q & ~mispredict;
        dx_pc_d      = stall_i ? dx_pc_q    : fd_pc_q;
        dx_pt_d      = stall_i ? dx_pt_q    : fd_pt_q;
        dx_tgt_d     = stall_i ? dx_tgt_q   : fd_tgt_q;
        upd_en_d     = resolve & (x_is_ctrl_i | dx_pt_q);
        upd_idx_d    = upd_en_d ? dx_pc_q[IDX_W+1:2]      : upd_idx_q;
        upd_target_d = upd_en_d ? x_target_i              : upd_target_q;
        upd_valid_d  = upd_en_d ? x_taken_i & x_is_ctrl_i : upd_valid_q;
        br_cnt_d     = (resolve & x_is_ctrl_i & ~&br_cnt_q) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
        mis_cnt_d    = (mispredict & ~&mis_cnt_q) ? mis_cnt_q + CNT_W'(1) : mis_cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fd_valid_q   <= 1'b0;
            fd_pc_q      <= '0;
            fd_pt_q      <= 1'b0;
            fd_tgt_q     <= '0;
            dx_valid_q   <= 1'b0;
            dx_pc_q      <= '0;
            dx_pt_q      <= 1'b0;
            dx_tgt_q     <= '0;
            upd_en_q     <= 1'b0;
            upd_idx_q    <= '0;
            upd_target_q <= '0;
            upd_valid_q  <= 1'b0;
            br_cnt_q     <= '0;
            mis_cnt_q    <= '0;
        end else begin
            fd_valid_q   <= fd_valid_d;
            fd_pc_q      <= fd_pc_d;
            fd_pt_q      <= fd_pt_d;
            fd_tgt_q     <= fd_tgt_d;
            dx_valid_q   <= dx_valid_d;
            dx_pc_q      <= dx_pc_d;
            dx_pt_q      <= dx_pt_d;
            dx_tgt_q     <= dx_tgt_d;
            upd_en_q     <= upd_en_d;
            upd_idx_q    <= upd_idx_d;
            upd_target_q <= upd_target_d;
            upd_valid_q  <= upd_valid_d;
            br_cnt_q     <= br_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    assign redirect_o    = mispredict & ~rst_i;
    assign flush_o       = redirect_o;
    assign redirect_pc_o = redirect_o ? act_next : '0;
    assign upd_en_o      = upd_en_q;
    assign upd_idx_o     = upd_idx_q;
    assign upd_target_o  = upd_target_q;
    assign upd_valid_o   = upd_valid_q;
    assign br_cnt_o      = br_cnt_q;
    assign mis_cnt_o     = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: scoreboard bench; a second instance with 2-bit counters checks saturation.
module tb_branch_resolve;
    logic        clk = 0, rst_i = 1, stall_i = 0;
    logic        f_valid_i = 0, f_pred_taken_i = 0, x_is_ctrl_i = 0, x_taken_i = 0;
    logic [31:0] f_pc_i = 0, f_pred_target_i = 0, x_target_i = 0;
    logic        redirect_o, flush_o, upd_en_o, upd_valid_o;
    logic [31:0] redirect_pc_o, upd_target_o, br_cnt_o, mis_cnt_o;
    logic [11:0] upd_idx_o;
    logic        s_redirect, s_flush, s_upd_en, s_upd_valid;
    logic [31:0] s_redirect_pc, s_upd_target;
    logic [11:0] s_upd_idx;
    logic [1:0]  s_br_cnt, s_mis_cnt;

    typedef struct packed { logic [11:0] idx; logic [31:0] tgt; logic vld; } upd_t;
    upd_t upd_q[$];
    upd_t exp_u;
    int checks = 0, errors = 0, br_m = 0, mis_m = 0;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .f_valid_i(f_valid_i), .f_pc_i(f_pc_i),
        .f_pred_taken_i(f_pred_taken_i), .f_pred_target_i(f_pred_target_i),
        .x_is_ctrl_i(x_is_ctrl_i), .x_taken_i(x_taken_i), .x_target_i(x_target_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
        .upd_en_o(upd_en_o), .upd_idx_o(upd_idx_o), .upd_target_o(upd_target_o),
        .upd_valid_o(upd_valid_o), .br_cnt_o(br_cnt_o), .mis_cnt_o(mis_cnt_o));

    branch_resolve #(.CNT_W(2)) sat (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .f_valid_i(f_valid_i), .f_pc_i(f_pc_i),
        .f_pred_taken_i(f_pred_taken_i), .f_pred_target_i(f_pred_target_i),
        .x_is_ctrl_i(x_is_ctrl_i), .x_taken_i(x_taken_i), .x_target_i(x_target_i),
        .redirect_o(s_redirect), .redirect_pc_o(s_redirect_pc), .flush_o(s_flush),
        .upd_en_o(s_upd_en), .upd_idx_o(s_upd_idx), .upd_target_o(s_upd_target),
        .upd_valid_o(s_upd_valid), .br_cnt_o(s_br_cnt), .mis_cnt_o(s_mis_cnt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt();
        chk("br_cnt", br_cnt_o, br_m);
        chk("mis_cnt", mis_cnt_o, mis_m);
        chk("sat_br_cnt", {30'd0, s_br_cnt}, br_m > 3 ? 3 : br_m);
        chk("sat_mis_cnt", {30'd0, s_mis_cnt}, mis_m > 3 ? 3 : mis_m);
    endtask

    always @(negedge clk) begin
        if (!rst_i && upd_en_o) begin
            if (upd_q.size() == 0) chk("upd_spurious", 1, 0);
            else begin
                exp_u = upd_q.pop_front();
                chk("upd_idx", {20'd0, upd_idx_o}, {20'd0, exp_u.idx});
                chk("upd_target", upd_target_o, exp_u.tgt);
                chk("upd_valid", upd_valid_o, exp_u.vld);
            end
        end
    end

    // one instruction through F/D/X with wrong-path fetches behind it
    task automatic run(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                       input logic ctrl, input logic tk, input logic [31:0] tgt);
        logic mis, upd;
        logic [31:0] nxt;
        f_valid_i = 1; f_pc_i = pc; f_pred_taken_i = pt; f_pred_target_i = ptgt;
        step();
        f_pc_i = pc + 32'h1000; f_pred_taken_i = 0;
        step();
        f_pc_i = pc + 32'h2000;
        x_is_ctrl_i = ctrl; x_taken_i = tk; x_target_i = tgt;
        mis = (pt != tk) | (pt & tk & (ptgt != tgt));
        nxt = tk ? tgt : pc + 32'd4;
        upd = ctrl | pt;
        if (upd) upd_q.push_back({pc[13:2], tgt, tk & ctrl});
        if (ctrl) br_m++;
        if (mis) mis_m++;
        @(negedge clk);
        chk("redirect", redirect_o, mis);
        chk("flush", flush_o, mis);
        chk("redirect_pc", redirect_pc_o, mis ? nxt : 32'd0);
        step();
        f_valid_i = 0;
        x_is_ctrl_i = mis; x_taken_i = mis; x_target_i = 32'h500;
        @(negedge clk);
        chk("upd_en", upd_en_o, upd);
        chk_cnt();
        if (mis) chk("killed_dx", redirect_o, 0);
        step();
        @(negedge clk);
        chk("upd_single", upd_en_o, 0);
        if (mis) chk("killed_fd", redirect_o, 0);
        step();
        x_is_ctrl_i = 0; x_taken_i = 0; x_target_i = 0;
    endtask

    initial begin
        #2;
        chk("rst_redirect", redirect_o, 0);
        chk("rst_redirect_pc", redirect_pc_o, 0);
        chk("rst_upd_en", upd_en_o, 0);
        chk("rst_upd_idx", {20'd0, upd_idx_o}, 0);
        chk("rst_upd_target", upd_target_o, 0);
        chk("rst_upd_valid", upd_valid_o, 0);
        chk_cnt();
        step();
        rst_i = 0;
        step();
        run(32'h100, 1, 32'h200, 1, 1, 32'h200);
        run(32'h104, 0, 32'h0, 1, 1, 32'h80);
        run(32'h108, 1, 32'h300, 1, 0, 32'h300);
        run(32'h10C, 1, 32'h400, 1, 1, 32'h404);
        // back-to-back correct predictions
        f_valid_i = 1; f_pc_i = 32'h400; f_pred_taken_i = 1; f_pred_target_i = 32'h480;
        step();
        f_pc_i = 32'h404; f_pred_target_i = 32'h500;
        step();
        f_valid_i = 0; f_pred_taken_i = 0;
        x_is_ctrl_i = 1; x_taken_i = 1; x_target_i = 32'h480;
        upd_q.push_back({12'h100, 32'h480, 1'b1});
        br_m++;
        @(negedge clk);
        chk("b2b_redirect0", redirect_o, 0);
        step();
        x_target_i = 32'h500;
        upd_q.push_back({12'h101, 32'h500, 1'b1});
        br_m++;
        @(negedge clk);
        chk("b2b_redirect1", redirect_o, 0);
        chk("b2b_upd0", upd_en_o, 1);
        step();
        x_is_ctrl_i = 0; x_taken_i = 0; x_target_i = 0;
        @(negedge clk);
        chk("b2b_upd1", upd_en_o, 1);
        step();
        @(negedge clk);
        chk("b2b_upd_end", upd_en_o, 0);
        chk_cnt();
        run(32'hFFFFFFFC, 1, 32'h1234, 0, 0, 32'h0);
        // stall held over the resolve cycle
        f_valid_i = 1; f_pc_i = 32'h200; f_pred_taken_i = 0;
        step();
        f_valid_i = 0;
        step();
        stall_i = 1; x_is_ctrl_i = 1; x_taken_i = 1; x_target_i = 32'h600;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_redirect", redirect_o, 0);
            chk("stall_upd", upd_en_o, 0);
            step();
        end
        chk_cnt();
        stall_i = 0;
        upd_q.push_back({12'h080, 32'h600, 1'b1});
        br_m++; mis_m++;
        @(negedge clk);
        chk("release_redirect", redirect_o, 1);
        chk("release_redirect_pc", redirect_pc_o, 32'h600);
        step();
        @(negedge clk);
        chk("release_once", redirect_o, 0);
        chk("release_upd", upd_en_o, 1);
        chk_cnt();
        step();
        x_is_ctrl_i = 0; x_taken_i = 0; x_target_i = 0;
        // reset pulsed while a redirect is active
        f_valid_i = 1; f_pc_i = 32'h300; f_pred_taken_i = 0;
        step();
        f_valid_i = 0;
        step();
        x_is_ctrl_i = 1; x_taken_i = 1; x_target_i = 32'h700;
        @(negedge clk);
        chk("pre_rst_redirect", redirect_o, 1);
        #1 rst_i = 1;
        #1;
        br_m = 0; mis_m = 0;
        chk("mid_rst_redirect", redirect_o, 0);
        chk("mid_rst_flush", flush_o, 0);
        chk("mid_rst_redirect_pc", redirect_pc_o, 0);
        chk("mid_rst_upd_en", upd_en_o, 0);
        chk("mid_rst_upd_target", upd_target_o, 0);
        chk_cnt();
        step();
        rst_i = 0; x_is_ctrl_i = 0; x_taken_i = 0; x_target_i = 0;
        @(negedge clk);
        chk("post_rst_upd", upd_en_o, 0);
        step();
        @(negedge clk);
        chk("post_rst_upd2", upd_en_o, 0);
        chk_cnt();
        chk("queue_empty", upd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution and recovery unit, the consumer side of the fetch-stage target predictor. It captures the prediction made for each fetched instruction and carries it alongside the instruction through D to X. In X it compares the prediction against the actual control-flow outcome, raises a redirect/flush on mispredict, and drives the registered write port that trains the predictor table. It also keeps saturating branch and mispredict counters for performance analysis.

## Interface
- XLEN, 32: PC/target width.
- IDX_W, 12: predictor index width; index = pc[IDX_W+1:2].
- CNT_W, 32: width of the statistics counters.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- stall_i  in  1  holds both prediction records and suppresses resolution.
- f_valid_i  in  1  fetch-stage instruction valid.
- f_pc_i  in  XLEN  fetch PC.
- f_pred_taken_i  in  1  predictor redirected fetch (table hit on a control opcode).
- f_pred_target_i  in  XLEN  predicted next PC.
- x_is_ctrl_i  in  1  X instruction is branch/JAL/JALR.
- x_taken_i  in  1  actual outcome; 1 for JAL/JALR, 0 when x_is_ctrl_i=0.
- x_target_i  in  XLEN  actual target when taken.
- redirect_o  out  1  mispredict detected this cycle.
- redirect_pc_o  out  XLEN  correct next PC.
- flush_o  out  1  kill F/D wrong-path instructions; equals redirect_o.
- upd_en_o  out  1  predictor write strobe.
- upd_idx_o  out  IDX_W  predictor write index.
- upd_target_o  out  XLEN  target to store.
- upd_valid_o  out  1  valid bit to store.
- br_cnt_o  out  CNT_W  resolved control instructions.
- mis_cnt_o  out  CNT_W  mispredicts.

## Operation
- Two prediction records, FD and DX, each holding {valid, pc, pred_taken, pred_target}.
- Each edge with stall_i=0 and no redirect: FD <= {f_valid_i, f_pc_i, f_pred_taken_i, f_pred_target_i}; DX <= FD.
- stall_i=1: both records hold. No resolution, no update, and the counters hold.
- Resolve when DX.valid=1 and stall_i=0. Let act_next = x_taken_i ? x_target_i : DX.pc+4, computed mod 2^XLEN.
- Mispredict when pred_taken != x_taken_i, or when both are 1 and pred_target != x_target_i.
- A predicted-taken non-control instruction (aliasing) is a mispredict; its correct next PC is pc+4.
- On mispredict: redirect_o=flush_o=1 and redirect_pc_o=act_next, combinationally in the resolve cycle. At the next edge, FD.valid and DX.valid <= 0, and the F input captured that cycle is discarded.
- Predictor update: requested when a resolve has x_is_ctrl_i=1, or has x_is_ctrl_i=0 with pred_taken=1.
  - Update fields: idx = DX.pc[IDX_W+1:2], target = x_target_i, valid = x_taken_i & x_is_ctrl_i.
  - The aliasing case therefore invalidates its entry.
- br_cnt_o increments on each resolve with x_is_ctrl_i=1. mis_cnt_o increments on each mispredict. Both saturate at 2^CNT_W-1.
- redirect_pc_o = 0 when redirect_o = 0.

## Timing
- Reset (asynchronous, any cycle, including mid-stall or mid-redirect):
  - Records invalid, all fields 0.
  - upd_en_o, upd_idx_o, upd_target_o, upd_valid_o = 0.
  - Counters = 0.
  - redirect_o, flush_o and redirect_pc_o are 0 while rst_i=1.
- Prediction-to-resolve latency: the prediction presented in cycle N resolves in cycle N+2 if there are no stalls.
- Redirect latency: 0 cycles, combinational from DX and the x_* inputs.
- Update latency: the upd_* outputs are registered. They are valid for exactly one cycle, the cycle after resolve. upd_en_o is held 0 otherwise, and the other upd_* fields hold their last value.
- Back-to-back resolves produce back-to-back single-cycle updates.
- Stall asserted in the resolve cycle: no redirect and no update that cycle. Resolution happens in the first cycle with stall_i=0.
- Counters update at the resolve edge and are visible one cycle after resolve.

## Test plan
- Correct taken prediction: f_pc=0x100, pred_taken=1, target=0x200. Two cycles later x_is_ctrl=1, taken=1, target=0x200 -> redirect_o=0; next cycle upd_en=1, idx=0x040, target=0x200, valid=1; br_cnt=1, mis_cnt=0.
- Not-predicted taken branch: pc=0x104, pred_taken=0; X reports taken to 0x80 -> redirect_o=1, redirect_pc=0x80, FD/DX invalid next cycle; update idx=0x041, valid=1; mis_cnt=1.
- Predicted taken, actually not taken: pc=0x108, pred 0x300; X not taken -> redirect_pc=0x10C, upd_valid=0.
- Wrong target on JALR: pred 0x400, actual 0x404 -> redirect_pc=0x404, update target=0x404.
- Aliasing, stall and wrap-around:
  - pc=0xFFFFFFFC predicted taken while x_is_ctrl=0 -> redirect_pc=0x00000000, upd_valid=0.
  - With stall_i=1 held 3 cycles over the resolve cycle, nothing fires until release, then exactly one redirect and one update occur.
- Reset and saturation:
  - rst_i pulsed mid-redirect -> all outputs 0 immediately, no update afterward.
  - With CNT_W=2, four mispredicts leave mis_cnt_o=3.
